// File: rtl/modinv_helper_init_gen.sv
// Initialisation sequencer for the modular invertor: streams operands A/Q out of their
// banks into the R/S/U/V working buffers. Optional feature macro: MODINV_INIT_ZEROCHK_EN.
module modinv_helper_init_gen #(
    parameter int OPERAND_NUM_WORDS = 8,
    parameter int OPERAND_ADDR_BITS = 3,
    parameter int BUFFER_NUM_WORDS  = 9,
    parameter int BUFFER_ADDR_BITS  = 4,
    parameter int WORD_WIDTH        = 32,
    parameter int READ_LATENCY      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [1:0]                   mode,
    output logic                         rdy,
    output logic                         done,
    output logic [OPERAND_ADDR_BITS-1:0] a_addr,
    output logic [OPERAND_ADDR_BITS-1:0] q_addr,
    input  logic [WORD_WIDTH-1:0]        a_din,
    input  logic [WORD_WIDTH-1:0]        q_din,
    output logic [BUFFER_ADDR_BITS-1:0]  r_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  u_addr,
    output logic [BUFFER_ADDR_BITS-1:0]  v_addr,
    output logic                         r_wren,
    output logic                         s_wren,
    output logic                         u_wren,
    output logic                         v_wren,
    output logic [WORD_WIDTH-1:0]        r_dout,
    output logic [WORD_WIDTH-1:0]        s_dout,
    output logic [WORD_WIDTH-1:0]        u_dout,
    output logic [WORD_WIDTH-1:0]        v_dout
`ifdef MODINV_INIT_ZEROCHK_EN
    ,
    output logic                         a_zero,
    output logic                         q_zero
`endif
);

    localparam int CNT_W = ((BUFFER_ADDR_BITS > OPERAND_ADDR_BITS) ?
                            BUFFER_ADDR_BITS : OPERAND_ADDR_BITS) + 2;
    localparam logic [CNT_W-1:0]             CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]             CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]             CNT_LAT    = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0]             CNT_RD_END = CNT_W'(OPERAND_NUM_WORDS);
    localparam logic [CNT_W-1:0]             CNT_LAST   = CNT_W'(BUFFER_NUM_WORDS + READ_LATENCY);
    localparam logic [WORD_WIDTH-1:0]        WORD_ZERO  = {WORD_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0]        WORD_ONE   = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BUFFER_ADDR_BITS-1:0]  BUF_ZERO   = {BUFFER_ADDR_BITS{1'b0}};
    localparam logic [OPERAND_ADDR_BITS-1:0] OP_ZERO    = {OPERAND_ADDR_BITS{1'b0}};

    generate
        if (BUFFER_NUM_WORDS < OPERAND_NUM_WORDS + 1) begin : g_bad_buffer_size
            $error("BUFFER_NUM_WORDS must be at least OPERAND_NUM_WORDS+1");
        end
        if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
            $error("READ_LATENCY must be in 1..3");
        end
    endgenerate

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                         state_r;
    logic [CNT_W-1:0]               cnt_r;
    logic [1:0]                     mode_r;
    logic                           rdy_r;
    logic                           done_r;
    logic                           wren_r;
    logic                           rd_vld_r;
    logic [OPERAND_ADDR_BITS-1:0]   op_addr_r;
    logic [BUFFER_ADDR_BITS-1:0]    buf_addr_r;
    logic [READ_LATENCY-1:0]        dv_pipe_r;

    logic                           start_s;
    logic                           last_s;
    logic                           rd_go_s;
    logic                           wr_go_s;
    logic                           dv_s;
    logic [CNT_W-1:0]               wr_idx_s;
    logic [WORD_WIDTH-1:0]          op_a_s;
    logic [WORD_WIDTH-1:0]          op_q_s;
    logic [WORD_WIDTH-1:0]          one_word_s;
    logic [WORD_WIDTH-1:0]          r_dout_s;
    logic [WORD_WIDTH-1:0]          s_dout_s;
    logic [WORD_WIDTH-1:0]          u_dout_s;
    logic [WORD_WIDTH-1:0]          v_dout_s;

    // Start/finish decode; the address for cycle c+1 is derived from the current count c
    always_comb begin
        start_s  = (state_r == ST_IDLE) && ena;
        last_s   = (state_r == ST_BUSY) && (cnt_r == CNT_LAST);
        rd_go_s  = (cnt_r < CNT_RD_END);
        wr_go_s  = (cnt_r >= CNT_LAT);
        wr_idx_s = cnt_r - CNT_LAT;
        dv_s     = dv_pipe_r[READ_LATENCY-1];
    end

    // Sequencer FSM: cycle counter, mode latch and registered bank/buffer controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            mode_r     <= 2'b00;
            rdy_r      <= 1'b1;
            done_r     <= 1'b0;
            wren_r     <= 1'b0;
            rd_vld_r   <= 1'b0;
            op_addr_r  <= OP_ZERO;
            buf_addr_r <= BUF_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r     <= 1'b0;
                    wren_r     <= 1'b0;
                    op_addr_r  <= OP_ZERO;
                    buf_addr_r <= BUF_ZERO;
                    if (start_s) begin
                        state_r  <= ST_BUSY;
                        cnt_r    <= CNT_ONE;
                        mode_r   <= mode;
                        rdy_r    <= 1'b0;
                        rd_vld_r <= 1'b1;
                    end else begin
                        rdy_r    <= 1'b1;
                        rd_vld_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (last_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= CNT_ZERO;
                        rdy_r      <= 1'b1;
                        done_r     <= 1'b1;
                        wren_r     <= 1'b0;
                        rd_vld_r   <= 1'b0;
                        op_addr_r  <= OP_ZERO;
                        buf_addr_r <= BUF_ZERO;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                        rd_vld_r   <= rd_go_s;
                        op_addr_r  <= rd_go_s ? cnt_r[OPERAND_ADDR_BITS-1:0] : OP_ZERO;
                        wren_r     <= wr_go_s;
                        buf_addr_r <= wr_go_s ? wr_idx_s[BUFFER_ADDR_BITS-1:0] : BUF_ZERO;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    rdy_r      <= 1'b1;
                    done_r     <= 1'b0;
                    wren_r     <= 1'b0;
                    rd_vld_r   <= 1'b0;
                    op_addr_r  <= OP_ZERO;
                    buf_addr_r <= BUF_ZERO;
                end
            endcase
        end
    end

    // Read-valid pipeline: marks the cycles in which bank data belongs to a real operand word
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_pipe_r <= {READ_LATENCY{1'b0}};
        end else begin
            dv_pipe_r[0] <= rd_vld_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dv_pipe_r[i] <= dv_pipe_r[i-1];
            end
        end
    end

    // Write-data select; bank data is gated so zero outputs never see bank contents
    always_comb begin
        op_a_s     = WORD_ZERO;
        op_q_s     = WORD_ZERO;
        one_word_s = WORD_ZERO;
        r_dout_s   = WORD_ZERO;
        s_dout_s   = WORD_ZERO;
        u_dout_s   = WORD_ZERO;
        v_dout_s   = WORD_ZERO;
        if (dv_s) begin
            op_a_s = a_din;
            op_q_s = q_din;
        end else begin
            op_a_s = WORD_ZERO;
            op_q_s = WORD_ZERO;
        end
        if (wren_r && (buf_addr_r == BUF_ZERO)) begin
            one_word_s = WORD_ONE;
        end else begin
            one_word_s = WORD_ZERO;
        end
        case (mode_r)
            2'b00: begin
                u_dout_s = op_q_s;
                v_dout_s = op_a_s;
                s_dout_s = one_word_s;
            end
            2'b01: begin
                u_dout_s = op_a_s;
                v_dout_s = op_q_s;
                r_dout_s = one_word_s;
            end
            2'b10: begin
                u_dout_s = op_q_s;
                v_dout_s = op_a_s;
            end
            2'b11: begin
                u_dout_s = WORD_ZERO;
                v_dout_s = WORD_ZERO;
            end
            default: begin
                u_dout_s = WORD_ZERO;
                v_dout_s = WORD_ZERO;
            end
        endcase
    end

`ifdef MODINV_INIT_ZEROCHK_EN
    logic a_or_r;
    logic q_or_r;
    logic a_zero_r;
    logic q_zero_r;

    // Operand-zero detection: OR-accumulate during the run, publish at completion
    always_ff @(posedge clk) begin
        if (rst) begin
            a_or_r   <= 1'b0;
            q_or_r   <= 1'b0;
            a_zero_r <= 1'b0;
            q_zero_r <= 1'b0;
        end else if (start_s) begin
            a_or_r <= 1'b0;
            q_or_r <= 1'b0;
        end else if (last_s) begin
            a_zero_r <= ~a_or_r;
            q_zero_r <= ~q_or_r;
        end else if (dv_s) begin
            a_or_r <= a_or_r | (|a_din);
            q_or_r <= q_or_r | (|q_din);
        end
    end

    assign a_zero = a_zero_r;
    assign q_zero = q_zero_r;
`endif

    assign rdy    = rdy_r;
    assign done   = done_r;
    assign a_addr = op_addr_r;
    assign q_addr = op_addr_r;
    assign r_addr = buf_addr_r;
    assign s_addr = buf_addr_r;
    assign u_addr = buf_addr_r;
    assign v_addr = buf_addr_r;
    assign r_wren = wren_r;
    assign s_wren = wren_r;
    assign u_wren = wren_r;
    assign v_wren = wren_r;
    assign r_dout = r_dout_s;
    assign s_dout = s_dout_s;
    assign u_dout = u_dout_s;
    assign v_dout = v_dout_s;

endmodule

// File: tb/tb_modinv_helper_init_gen.sv
// Directed bench for modinv_helper_init_gen: default instance (latency 1) and a latency-3 instance.
module tb_modinv_helper_init_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena_tb;
    logic [1:0]  mode_tb;
    int          sel;
    bit          poison;
    logic [31:0] a_set [8];
    logic [31:0] q_set [8];

    logic        ena0, rdy0, done0, r_wren0, s_wren0, u_wren0, v_wren0;
    logic        ena1, rdy1, done1, r_wren1, s_wren1, u_wren1, v_wren1;
    logic [2:0]  a_addr0, q_addr0, a_addr1, q_addr1;
    logic [3:0]  r_addr0, s_addr0, u_addr0, v_addr0, r_addr1, s_addr1, u_addr1, v_addr1;
    logic [31:0] a_din0, q_din0, a_din1, q_din1;
    logic [31:0] r_dout0, s_dout0, u_dout0, v_dout0, r_dout1, s_dout1, u_dout1, v_dout1;
    logic [31:0] a_p0, q_p0;
    logic [31:0] a_p1 [3];
    logic [31:0] q_p1 [3];
`ifdef MODINV_INIT_ZEROCHK_EN
    logic        a_zero0, q_zero0, a_zero1, q_zero1;
`endif

    assign ena0   = ena_tb && (sel == 0);
    assign ena1   = ena_tb && (sel == 1);
    assign a_din0 = poison ? 32'hDEADBEEF : a_p0;
    assign q_din0 = poison ? 32'hDEADBEEF : q_p0;
    assign a_din1 = poison ? 32'hDEADBEEF : a_p1[2];
    assign q_din1 = poison ? 32'hDEADBEEF : q_p1[2];

    // Operand bank models with 1- and 3-cycle read latency
    always @(posedge clk) begin
        a_p0    <= a_set[a_addr0];
        q_p0    <= q_set[q_addr0];
        a_p1[0] <= a_set[a_addr1];
        q_p1[0] <= q_set[q_addr1];
        a_p1[1] <= a_p1[0];
        q_p1[1] <= q_p1[0];
        a_p1[2] <= a_p1[1];
        q_p1[2] <= q_p1[1];
    end

    modinv_helper_init_gen dut (
        .clk(clk), .rst(rst), .ena(ena0), .mode(mode_tb), .rdy(rdy0), .done(done0),
        .a_addr(a_addr0), .q_addr(q_addr0), .a_din(a_din0), .q_din(q_din0),
        .r_addr(r_addr0), .s_addr(s_addr0), .u_addr(u_addr0), .v_addr(v_addr0),
        .r_wren(r_wren0), .s_wren(s_wren0), .u_wren(u_wren0), .v_wren(v_wren0),
        .r_dout(r_dout0), .s_dout(s_dout0), .u_dout(u_dout0), .v_dout(v_dout0)
`ifdef MODINV_INIT_ZEROCHK_EN
        , .a_zero(a_zero0), .q_zero(q_zero0)
`endif
    );

    modinv_helper_init_gen #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ena(ena1), .mode(mode_tb), .rdy(rdy1), .done(done1),
        .a_addr(a_addr1), .q_addr(q_addr1), .a_din(a_din1), .q_din(q_din1),
        .r_addr(r_addr1), .s_addr(s_addr1), .u_addr(u_addr1), .v_addr(v_addr1),
        .r_wren(r_wren1), .s_wren(s_wren1), .u_wren(u_wren1), .v_wren(v_wren1),
        .r_dout(r_dout1), .s_dout(s_dout1), .u_dout(u_dout1), .v_dout(v_dout1)
`ifdef MODINV_INIT_ZEROCHK_EN
        , .a_zero(a_zero1), .q_zero(q_zero1)
`endif
    );

    // View of the instance under test
    logic        s_rdy, s_done, s_rw, s_sw, s_uw, s_vw;
    logic [2:0]  s_aa, s_qa;
    logic [3:0]  s_ra, s_sa, s_ua, s_va;
    logic [31:0] s_rd, s_sd, s_ud, s_vd;
    logic        s_az, s_qz;
    always_comb begin
        s_az = 1'b0;
        s_qz = 1'b0;
        if (sel == 0) begin
            s_rdy = rdy0; s_done = done0; s_aa = a_addr0; s_qa = q_addr0;
            s_ra = r_addr0; s_sa = s_addr0; s_ua = u_addr0; s_va = v_addr0;
            s_rw = r_wren0; s_sw = s_wren0; s_uw = u_wren0; s_vw = v_wren0;
            s_rd = r_dout0; s_sd = s_dout0; s_ud = u_dout0; s_vd = v_dout0;
`ifdef MODINV_INIT_ZEROCHK_EN
            s_az = a_zero0; s_qz = q_zero0;
`endif
        end else begin
            s_rdy = rdy1; s_done = done1; s_aa = a_addr1; s_qa = q_addr1;
            s_ra = r_addr1; s_sa = s_addr1; s_ua = u_addr1; s_va = v_addr1;
            s_rw = r_wren1; s_sw = s_wren1; s_uw = u_wren1; s_vw = v_wren1;
            s_rd = r_dout1; s_sd = s_dout1; s_ud = u_dout1; s_vd = v_dout1;
`ifdef MODINV_INIT_ZEROCHK_EN
            s_az = a_zero1; s_qz = q_zero1;
`endif
        end
    end

    typedef struct {
        int          inst;
        logic [1:0]  mode;
        bit          poison;
        int          u_src;   // 0 zero, 1 operand A, 2 operand Q
        int          v_src;
        logic [31:0] r0;
        logic [31:0] s0;
        int          e_first;
        int          e_last;
        int          e_done;
        int          e_low;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cap_r [9];
    logic [31:0] cap_s [9];
    logic [31:0] cap_u [9];
    logic [31:0] cap_v [9];
    int          wr_n, first_c, last_c, done_c, low_n;
    bit          dirty;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input int src, input int k);
        if (k >= 8) return 32'h0;
        if (src == 1) return a_set[k];
        if (src == 2) return q_set[k];
        return 32'h0;
    endfunction

    // Runs from the accept edge up to the done cycle, recording every buffer write
    task automatic run_capture(input logic [1:0] nxt_mode, input bit hold);
        int c;
        bit got;
        wr_n = 0; first_c = 0; last_c = 0; done_c = 0; low_n = 0; dirty = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cap_r[k] = 32'hA5A5A5A5; cap_s[k] = 32'hA5A5A5A5;
            cap_u[k] = 32'hA5A5A5A5; cap_v[k] = 32'hA5A5A5A5;
        end
        c = 0;
        got = 1'b0;
        while (!got && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (!hold && c == 1) ena_tb = 1'b0;
            if (c == 3) mode_tb = ~mode_tb;
            if (!hold && c == 4) ena_tb = 1'b1;
            if (!hold && c == 5) ena_tb = 1'b0;
            if (!s_rdy) low_n++;
            if (s_aa !== s_qa) dirty = 1'b1;
            if (c <= 8) begin
                if (s_aa !== 3'(c - 1)) dirty = 1'b1;
            end else if (s_aa !== 3'd0) dirty = 1'b1;
            if (s_rw) begin
                if (!(s_sw && s_uw && s_vw)) dirty = 1'b1;
                if (s_ra !== s_sa || s_ra !== s_ua || s_ra !== s_va) dirty = 1'b1;
                if (wr_n >= 9 || int'(s_ra) != wr_n) begin
                    dirty = 1'b1;
                end else begin
                    cap_r[wr_n] = s_rd; cap_s[wr_n] = s_sd;
                    cap_u[wr_n] = s_ud; cap_v[wr_n] = s_vd;
                end
                if (wr_n == 0) first_c = c;
                last_c = c;
                wr_n++;
            end else begin
                if (s_sw || s_uw || s_vw) dirty = 1'b1;
                if ((s_ra | s_sa | s_ua | s_va) !== 4'd0) dirty = 1'b1;
                if ((s_rd | s_sd | s_ud | s_vd) !== 32'h0) dirty = 1'b1;
            end
            if (s_done) begin
                got = 1'b1;
                done_c = c;
                if (s_rdy !== 1'b1) dirty = 1'b1;
                if (hold) mode_tb = nxt_mode;
            end
        end
        chk("run completes within budget", {31'd0, got}, 32'd1);
    endtask

    task automatic check_run(input string tag, input vec_t v);
        chk({tag, " write count"}, wr_n, 9);
        chk({tag, " first write cycle"}, first_c, v.e_first);
        chk({tag, " last write cycle"}, last_c, v.e_last);
        chk({tag, " done cycle"}, done_c, v.e_done);
        chk({tag, " rdy-low cycles"}, low_n, v.e_low);
        chk({tag, " protocol clean"}, {31'd0, dirty}, 32'd0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s u[%0d]", tag, k), cap_u[k], src_word(v.u_src, k));
            chk($sformatf("%s v[%0d]", tag, k), cap_v[k], src_word(v.v_src, k));
            chk($sformatf("%s r[%0d]", tag, k), cap_r[k], (k == 0) ? v.r0 : 32'h0);
            chk($sformatf("%s s[%0d]", tag, k), cap_s[k], (k == 0) ? v.s0 : 32'h0);
        end
    endtask

    task automatic start(input logic [1:0] m);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle before start", {31'd0, s_rdy}, 32'd1);
        ena_tb  = 1'b1;
        mode_tb = m;
    endtask

    vec_t vecs [5];
    vec_t v;
    bit   saw_done;

    initial begin
        vecs[0] = '{0, 2'b00, 1'b0, 2, 1, 32'h0, 32'h1, 2, 10, 11, 10};
        vecs[1] = '{1, 2'b01, 1'b0, 1, 2, 32'h1, 32'h0, 4, 12, 13, 12};
        vecs[2] = '{0, 2'b11, 1'b1, 0, 0, 32'h0, 32'h0, 2, 10, 11, 10};
        vecs[3] = '{0, 2'b10, 1'b0, 2, 1, 32'h0, 32'h0, 2, 10, 11, 10};
        vecs[4] = '{1, 2'b11, 1'b1, 0, 0, 32'h0, 32'h0, 4, 12, 13, 12};
        for (int k = 0; k < 8; k++) begin
            a_set[k] = 32'h11111111 * 32'(k + 1);
            q_set[k] = 32'hF0000000 + 32'(k);
        end
        rst = 1'b1; ena_tb = 1'b0; mode_tb = 2'b00; sel = 0; poison = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            chk($sformatf("reset rdy inst%0d", i), {31'd0, s_rdy}, 32'd1);
            chk($sformatf("reset done inst%0d", i), {31'd0, s_done}, 32'd0);
            chk($sformatf("reset wren inst%0d", i), {28'd0, s_rw, s_sw, s_uw, s_vw}, 32'd0);
            chk($sformatf("reset addr inst%0d", i), {21'd0, s_aa, s_ra, s_sa, s_ua}, 32'd0);
            chk($sformatf("reset dout inst%0d", i), s_rd | s_sd | s_ud | s_vd, 32'h0);
        end
        rst = 1'b0;

        for (int n = 0; n < 5; n++) begin
            sel    = vecs[n].inst;
            poison = vecs[n].poison;
            start(vecs[n].mode);
            run_capture(2'b00, 1'b0);
            check_run($sformatf("vec%0d", n), vecs[n]);
`ifdef MODINV_INIT_ZEROCHK_EN
            chk($sformatf("vec%0d a_zero", n), {31'd0, s_az}, 32'd0);
            chk($sformatf("vec%0d q_zero", n), {31'd0, s_qz}, 32'd0);
`endif
        end
        poison = 1'b0;

        // Back-to-back: ena held high, mode 00 then 10 switched on the done cycle
        sel = 0;
        start(2'b00);
        run_capture(2'b10, 1'b1);
        check_run("chain1", vecs[0]);
        run_capture(2'b00, 1'b0);
        check_run("chain2", vecs[3]);

        // Reset in the middle of a run
        start(2'b00);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) ena_tb = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-run reset wren", {28'd0, s_rw, s_sw, s_uw, s_vw}, 32'd0);
        chk("mid-run reset rdy", {31'd0, s_rdy}, 32'd1);
        chk("mid-run reset done", {31'd0, s_done}, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (s_done) saw_done = 1'b1;
        end
        chk("no done after reset", {31'd0, saw_done}, 32'd0);
        start(2'b00);
        run_capture(2'b00, 1'b0);
        check_run("post-reset", vecs[0]);

`ifdef MODINV_INIT_ZEROCHK_EN
        for (int k = 0; k < 8; k++) begin
            a_set[k] = 32'h0;
            q_set[k] = 32'h0;
        end
        q_set[7] = 32'h1;
        start(2'b00);
        run_capture(2'b00, 1'b0);
        check_run("zerochk", vecs[0]);
        chk("zerochk a_zero at done", {31'd0, s_az}, 32'd1);
        chk("zerochk q_zero at done", {31'd0, s_qz}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("zerochk a_zero held", {31'd0, s_az}, 32'd1);
        chk("zerochk q_zero held", {31'd0, s_qz}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
